// File: rtl/combo_lock_param.sv
// ---------------------------------------------------------------------------
// combo_lock_param
//   Parametrised digit-entry combination lock. Each rising edge of enter
//   submits one digit, which is compared in order against CODE (first digit
//   in the most-significant slice). A complete correct code opens the lock
//   for UNLOCK_CYC cycles. MAX_FAIL consecutive wrong codes start a
//   LOCKOUT_CYC-cycle lockout. A partial entry with no new digit for
//   IDLE_CYC cycles is discarded.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-low
//   enter        in   level; each 0->1 transition submits one digit
//   digit        in   digit value sampled on the enter edge
//   clear        in   abort the partial entry (no failure counted)
//   relock       in   end the unlocked window early
//   unlocked     out  correct code accepted, hold window active
//   locked_out   out  lockout active, all entry ignored
//   bad_code     out  one-cycle pulse per wrong complete code
//   digit_count  out  digits captured in the current attempt
//   fail_count   out  consecutive failed codes
// ---------------------------------------------------------------------------
module combo_lock_param #(
    parameter int                          DIGIT_W     = 4,
    parameter int                          CODE_LEN    = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] CODE        = 16'h9979,
    parameter int                          MAX_FAIL    = 3,
    parameter int                          UNLOCK_CYC  = 500,
    parameter int                          LOCKOUT_CYC = 1000,
    parameter int                          IDLE_CYC    = 2000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enter,
    input  logic [DIGIT_W-1:0]              digit,
    input  logic                            clear,
    input  logic                            relock,
    output logic                            unlocked,
    output logic                            locked_out,
    output logic                            bad_code,
    output logic [$clog2(CODE_LEN+1)-1:0]   digit_count,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count
);

    localparam int DC_W   = $clog2(CODE_LEN + 1);
    localparam int FC_W   = $clog2(MAX_FAIL + 1);
    // One timer is shared by the three states; size it for the longest interval.
    localparam int T_MAX1 = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int T_MAX  = (T_MAX1 > IDLE_CYC) ? T_MAX1 : IDLE_CYC;
    localparam int TMR_W  = $clog2(T_MAX + 1);

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              enter_q;
    logic [DC_W-1:0]   dcnt_q, dcnt_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic              match_q, match_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              unlocked_q, unlocked_d;
    logic              locked_q, locked_d;
    logic              bad_q, bad_d;

    logic              enter_edge;
    logic              digit_ok;
    logic              match_new;

    // Expected digit for position idx; position 0 lives in the MS slice.
    function automatic logic [DIGIT_W-1:0] code_digit(input logic [DC_W-1:0] idx);
        int shift;
        shift = (CODE_LEN - 1 - int'(idx)) * DIGIT_W;
        return DIGIT_W'(CODE >> shift);
    endfunction

    // Edge detection runs in every state so an edge seen during OPEN or
    // LOCKOUT is consumed there and never replayed in ENTRY.
    assign enter_edge = enter & ~enter_q;
    assign digit_ok   = (digit == code_digit(dcnt_q));
    assign match_new  = match_q & digit_ok;

    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        fcnt_d     = fcnt_q;
        match_d    = match_q;
        tmr_d      = tmr_q;
        unlocked_d = unlocked_q;
        locked_d   = locked_q;
        bad_d      = 1'b0;

        case (state_q)
            ST_ENTRY: begin
                if (clear) begin
                    // clear beats a coincident edge: the digit is dropped
                    dcnt_d  = '0;
                    match_d = 1'b1;
                    tmr_d   = '0;
                end else if (enter_edge) begin
                    tmr_d = '0;
                    if (dcnt_q == DC_W'(CODE_LEN - 1)) begin
                        dcnt_d  = '0;
                        match_d = 1'b1;
                        if (match_new) begin
                            state_d    = ST_OPEN;
                            unlocked_d = 1'b1;
                            fcnt_d     = '0;
                        end else begin
                            bad_d = 1'b1;
                            if (fcnt_q == FC_W'(MAX_FAIL - 1)) begin
                                fcnt_d   = FC_W'(MAX_FAIL);
                                state_d  = ST_LOCKOUT;
                                locked_d = 1'b1;
                            end else begin
                                fcnt_d = fcnt_q + 1'b1;
                            end
                        end
                    end else begin
                        dcnt_d  = dcnt_q + 1'b1;
                        match_d = match_new;
                    end
                end else if (dcnt_q != '0) begin
                    // stale partial entry expires IDLE_CYC cycles after the last digit
                    if (tmr_q == TMR_W'(IDLE_CYC - 1)) begin
                        dcnt_d  = '0;
                        match_d = 1'b1;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end

            ST_OPEN: begin
                if (relock || (tmr_q == TMR_W'(UNLOCK_CYC - 1))) begin
                    state_d    = ST_ENTRY;
                    unlocked_d = 1'b0;
                    tmr_d      = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            ST_LOCKOUT: begin
                if (tmr_q == TMR_W'(LOCKOUT_CYC - 1)) begin
                    state_d  = ST_ENTRY;
                    locked_d = 1'b0;
                    fcnt_d   = '0;
                    tmr_d    = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end

            default: begin
                state_d    = ST_ENTRY;
                dcnt_d     = '0;
                fcnt_d     = '0;
                match_d    = 1'b1;
                tmr_d      = '0;
                unlocked_d = 1'b0;
                locked_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_ENTRY;
            enter_q    <= 1'b0;
            dcnt_q     <= '0;
            fcnt_q     <= '0;
            match_q    <= 1'b1;
            tmr_q      <= '0;
            unlocked_q <= 1'b0;
            locked_q   <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            enter_q    <= enter;
            dcnt_q     <= dcnt_d;
            fcnt_q     <= fcnt_d;
            match_q    <= match_d;
            tmr_q      <= tmr_d;
            unlocked_q <= unlocked_d;
            locked_q   <= locked_d;
            bad_q      <= bad_d;
        end
    end

    assign unlocked    = unlocked_q;
    assign locked_out  = locked_q;
    assign bad_code    = bad_q;
    assign digit_count = dcnt_q;
    assign fail_count  = fcnt_q;

endmodule

// File: tb/tb_combo_lock_param.sv
module tb_combo_lock_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic       reset, enter, clear, relock;
    logic [3:0] digit;
    logic       unlocked, locked_out, bad_code;
    logic [2:0] digit_count;
    logic [1:0] fail_count;

    // DIGIT_W=8, CODE_LEN=6, MAX_FAIL=1 instance
    logic       p_enter, p_clear, p_relock;
    logic [7:0] p_digit;
    logic       p_unlocked, p_locked_out, p_bad_code;
    logic [2:0] p_digit_count;
    logic [0:0] p_fail_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bad_seen = 0;
    int p_bad_seen = 0;

    combo_lock_param dut (
        .clk(clk), .reset(reset), .enter(enter), .digit(digit), .clear(clear), .relock(relock),
        .unlocked(unlocked), .locked_out(locked_out), .bad_code(bad_code),
        .digit_count(digit_count), .fail_count(fail_count)
    );

    combo_lock_param #(
        .DIGIT_W(8), .CODE_LEN(6), .CODE(48'h0A0B0C0D0E0F), .MAX_FAIL(1)
    ) dut_p (
        .clk(clk), .reset(reset), .enter(p_enter), .digit(p_digit), .clear(p_clear), .relock(p_relock),
        .unlocked(p_unlocked), .locked_out(p_locked_out), .bad_code(p_bad_code),
        .digit_count(p_digit_count), .fail_count(p_fail_count)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bad_code === 1'b1) bad_seen++;
        if (p_bad_code === 1'b1) p_bad_seen++;
    endtask

    task automatic pulse(input logic [3:0] d);
        digit = d;
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            pulse(c[15-4*i -: 4]);
            if (i < 3) tick();
        end
    endtask

    task automatic p_pulse(input logic [7:0] d);
        p_digit = d;
        p_enter = 1'b1;
        tick();
        p_enter = 1'b0;
    endtask

    task automatic p_enter_code(input logic [47:0] c);
        for (int i = 0; i < 6; i++) begin
            p_pulse(c[47-8*i -: 8]);
            if (i < 5) tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if ({unlocked, locked_out, bad_code, digit_count, fail_count} !== 8'h00) begin errors++; $display("FAIL reset_outputs: got %b expected 00000000", {unlocked, locked_out, bad_code, digit_count, fail_count}); end
        checks++; if ({p_unlocked, p_locked_out, p_bad_code, p_digit_count, p_fail_count} !== 7'h00) begin errors++; $display("FAIL reset_outputs_p: got %b expected 0000000", {p_unlocked, p_locked_out, p_bad_code, p_digit_count, p_fail_count}); end
        reset = 1'b1;
        tick();
        checks++; if ({unlocked, locked_out, bad_code, digit_count, fail_count} !== 8'h00) begin errors++; $display("FAIL post_reset_idle: got %b expected 00000000", {unlocked, locked_out, bad_code, digit_count, fail_count}); end
    endtask

    task automatic test_correct_code();
        int b0;
        int hi;
        b0 = bad_seen;
        enter_code(16'h9979);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL t1_unlock: got %b expected 1", unlocked); end
        checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL t1_dcount: got %0d expected 0", digit_count); end
        checks++; if (fail_count !== 2'd0) begin errors++; $display("FAIL t1_fcount: got %0d expected 0", fail_count); end
        hi = 0;
        repeat (499) begin
            tick();
            if (unlocked === 1'b1) hi++;
        end
        checks++; if (hi !== 499) begin errors++; $display("FAIL t1_hold: got %0d high cycles after edge expected 499", hi); end
        tick();
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL t1_hold_end: got %b expected 0", unlocked); end
        checks++; if (bad_seen !== b0) begin errors++; $display("FAIL t1_no_bad: got %0d pulses expected 0", bad_seen - b0); end
    endtask

    task automatic test_wrong_code();
        int b0;
        b0 = bad_seen;
        pulse(4'h9); tick();
        pulse(4'h9); tick();
        pulse(4'h7);
        checks++; if (digit_count !== 3'd3) begin errors++; $display("FAIL t2_dcount3: got %0d expected 3", digit_count); end
        tick();
        pulse(4'h8);
        checks++; if (bad_code !== 1'b1) begin errors++; $display("FAIL t2_bad_pulse: got %b expected 1", bad_code); end
        checks++; if (fail_count !== 2'd1) begin errors++; $display("FAIL t2_fcount: got %0d expected 1", fail_count); end
        checks++; if ({unlocked, digit_count} !== 4'b0000) begin errors++; $display("FAIL t2_state: got %b expected 0000", {unlocked, digit_count}); end
        tick();
        checks++; if (bad_code !== 1'b0) begin errors++; $display("FAIL t2_bad_width: got %b expected 0", bad_code); end
        checks++; if (bad_seen !== b0 + 1) begin errors++; $display("FAIL t2_bad_once: got %0d pulses expected 1", bad_seen - b0); end
        enter_code(16'h9979);
        checks++; if ({unlocked, fail_count} !== 3'b100) begin errors++; $display("FAIL t2_recover: got %b expected 100", {unlocked, fail_count}); end
        relock = 1'b1; tick(); relock = 1'b0;
        tick();
    endtask

    task automatic test_lockout();
        int b0;
        int l0;
        b0 = bad_seen;
        for (int k = 0; k < 3; k++) begin
            enter_code(16'h1234);
            checks++; if (fail_count !== 2'(k + 1)) begin errors++; $display("FAIL t3_fcount%0d: got %0d expected %0d", k, fail_count, k + 1); end
            checks++; if (locked_out !== (k == 2)) begin errors++; $display("FAIL t3_locked%0d: got %b expected %b", k, locked_out, (k == 2)); end
            if (k < 2) tick();
        end
        l0 = cyc;
        checks++; if (bad_seen !== b0 + 3) begin errors++; $display("FAIL t3_bad_count: got %0d expected 3", bad_seen - b0); end
        tick();
        enter_code(16'h9979);
        checks++; if ({unlocked, digit_count, locked_out} !== 5'b00001) begin errors++; $display("FAIL t3_ignored: got %b expected 00001", {unlocked, digit_count, locked_out}); end
        while (cyc < l0 + 999) tick();
        checks++; if ({locked_out, fail_count} !== 3'b111) begin errors++; $display("FAIL t3_lock_hold: got %b expected 111", {locked_out, fail_count}); end
        tick();
        checks++; if ({locked_out, fail_count} !== 3'b000) begin errors++; $display("FAIL t3_lock_end: got %b expected 000", {locked_out, fail_count}); end
        tick();
        enter_code(16'h9979);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL t3_unlock_after: got %b expected 1", unlocked); end
        relock = 1'b1; tick(); relock = 1'b0;
        tick();
    endtask

    task automatic test_edge_clear_timeout();
        int b0;
        int e0;
        digit = 4'h9;
        enter = 1'b1;
        repeat (5) tick();
        enter = 1'b0;
        tick();
        checks++; if (digit_count !== 3'd1) begin errors++; $display("FAIL t4_held: got %0d expected 1", digit_count); end
        clear = 1'b1; tick(); clear = 1'b0;
        b0 = bad_seen;
        pulse(4'h9); tick();
        pulse(4'h9); tick();
        checks++; if (digit_count !== 3'd2) begin errors++; $display("FAIL t4_two: got %0d expected 2", digit_count); end
        clear = 1'b1; tick(); clear = 1'b0;
        checks++; if ({digit_count, fail_count} !== 5'b00000) begin errors++; $display("FAIL t4_clear: got %b expected 00000", {digit_count, fail_count}); end
        checks++; if (bad_seen !== b0) begin errors++; $display("FAIL t4_clear_nobad: got %0d pulses expected 0", bad_seen - b0); end
        pulse(4'h9); tick();
        pulse(4'h9);
        e0 = cyc;
        while (cyc < e0 + 1999) tick();
        checks++; if (digit_count !== 3'd2) begin errors++; $display("FAIL t4_idle_hold: got %0d expected 2", digit_count); end
        tick();
        checks++; if ({digit_count, fail_count} !== 5'b00000) begin errors++; $display("FAIL t4_idle_expire: got %b expected 00000", {digit_count, fail_count}); end
        pulse(4'h1); tick();
        digit = 4'h9;
        enter = 1'b1;
        clear = 1'b1;
        tick();
        enter = 1'b0;
        clear = 1'b0;
        checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL t4_clear_edge: got %0d expected 0", digit_count); end
        tick();
        enter_code(16'h9979);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL t4_after_clear: got %b expected 1", unlocked); end
        relock = 1'b1; tick(); relock = 1'b0;
        tick();
    endtask

    task automatic test_relock_reset();
        int u0;
        enter_code(16'h9979);
        u0 = cyc;
        tick();
        pulse(4'h9);
        checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL t5_open_ignore: got %0d expected 0", digit_count); end
        clear = 1'b1; tick(); clear = 1'b0;
        while (cyc < u0 + 10) tick();
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL t5_still_open: got %b expected 1", unlocked); end
        relock = 1'b1; tick(); relock = 1'b0;
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL t5_relock: got %b expected 0", unlocked); end
        pulse(4'h9); tick();
        pulse(4'h9); tick();
        checks++; if (digit_count !== 3'd2) begin errors++; $display("FAIL t5_partial: got %0d expected 2", digit_count); end
        reset = 1'b0; tick(); reset = 1'b1;
        checks++; if ({unlocked, locked_out, bad_code, digit_count, fail_count} !== 8'h00) begin errors++; $display("FAIL t5_reset_mid: got %b expected 00000000", {unlocked, locked_out, bad_code, digit_count, fail_count}); end
        enter_code(16'h9979);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL t5_unlock_after_reset: got %b expected 1", unlocked); end
        reset = 1'b0; tick(); reset = 1'b1;
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL t5_reset_open: got %b expected 0", unlocked); end
        tick();
        enter_code(16'h9979);
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL t5_reunlock: got %b expected 1", unlocked); end
        relock = 1'b1; tick(); relock = 1'b0;
        tick();
    endtask

    task automatic test_param();
        int b0;
        p_enter_code(48'h0A0B0C0D0E0F);
        checks++; if ({p_unlocked, p_fail_count} !== 2'b10) begin errors++; $display("FAIL t6_unlock: got %b expected 10", {p_unlocked, p_fail_count}); end
        p_relock = 1'b1; tick(); p_relock = 1'b0;
        checks++; if (p_unlocked !== 1'b0) begin errors++; $display("FAIL t6_relock: got %b expected 0", p_unlocked); end
        tick();
        b0 = p_bad_seen;
        p_enter_code(48'h0A0B0C0D0E00);
        checks++; if ({p_bad_code, p_locked_out, p_fail_count, p_unlocked} !== 4'b1110) begin errors++; $display("FAIL t6_lockout: got %b expected 1110", {p_bad_code, p_locked_out, p_fail_count, p_unlocked}); end
        tick();
        checks++; if (p_bad_seen !== b0 + 1) begin errors++; $display("FAIL t6_bad_once: got %0d expected 1", p_bad_seen - b0); end
        p_enter_code(48'h0A0B0C0D0E0F);
        checks++; if ({p_unlocked, p_locked_out} !== 2'b01) begin errors++; $display("FAIL t6_locked_ignore: got %b expected 01", {p_unlocked, p_locked_out}); end
        reset = 1'b0; tick(); reset = 1'b1;
        checks++; if ({p_locked_out, p_fail_count, p_digit_count} !== 5'b00000) begin errors++; $display("FAIL t6_reset_lockout: got %b expected 00000", {p_locked_out, p_fail_count, p_digit_count}); end
        tick();
        p_enter_code(48'h0A0B0C0D0E0F);
        checks++; if (p_unlocked !== 1'b1) begin errors++; $display("FAIL t6_unlock_after_reset: got %b expected 1", p_unlocked); end
    endtask

    initial begin
        reset    = 1'b0;
        enter    = 1'b0;
        clear    = 1'b0;
        relock   = 1'b0;
        digit    = 4'h0;
        p_enter  = 1'b0;
        p_clear  = 1'b0;
        p_relock = 1'b0;
        p_digit  = 8'h00;
        test_reset();
        test_correct_code();
        test_wrong_code();
        test_lockout();
        test_edge_clear_timeout();
        test_relock_reset();
        test_param();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
